movement_control: RTL and testbench
===================================

MOVEMENT_CONTROL -- requirements
Module: movement_control

Interface
REQ-001 SHALL have parameter WD_LIMIT, default 255: max cycles spent in one CLEAR/DRAW pass before abort.
REQ-002 SHALL have parameter STEPS, default 1: pixel steps per axis per object per frame, range 1..15.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 tick  input  1  frame strobe, one clk wide.
REQ-006 p_left, p_right, p_up, p_down  input  1 each  crosshair direction requests.
REQ-007 b_left, b_right, b_up, b_down  input  1 each  bird direction requests.
REQ-008 enable  input  1  datapath pass-complete flag.
REQ-009 control  output  4  datapath state code.
REQ-010 PorB  output  1  object select; 0 = crosshair, 1 = bird.
REQ-011 busy  output  1  high whenever control != HOLD.
REQ-012 overrun  output  1  one-cycle pulse when a tick is dropped.
REQ-013 timeout  output  1  sticky flag for a watchdog abort; cleared only by reset.

Function
REQ-014 control codes SHALL be: PREHOLD 0100, HOLD 0000, CLEAR 0001, LEFT 0011, RIGHT 0010, DOWN 0110, UP 0111, DRAW 0101.
REQ-015 Per-object sequence SHALL be CLEAR -> horizontal moves -> vertical moves -> DRAW.
REQ-016 Frame sequence SHALL be HOLD -> crosshair sequence (PorB=0) -> bird sequence (PorB=1) -> HOLD.
REQ-017 PorB SHALL change only on the cycle entering CLEAR, and is constant for the rest of that object's sequence.
REQ-018 In HOLD, a high tick SHALL latch all eight direction inputs and start the frame on the next cycle.
REQ-019 Latched left and right both high SHALL produce no horizontal move; latched up and down both high SHALL produce no vertical move.
REQ-020 A requested direction SHALL occupy exactly STEPS consecutive cycles of LEFT/RIGHT/UP/DOWN; an unrequested axis takes zero cycles.
REQ-021 With no direction requested for an object, CLEAR SHALL be followed directly by DRAW.
REQ-022 CLEAR and DRAW SHALL each be held until enable is sampled high, then exit on the next edge.
REQ-023 enable sampled on the first cycle of any CLEAR/DRAW visit SHALL be ignored (stale from the prior pass); it qualifies from the second cycle on.
REQ-024 A per-visit cycle counter, 8 bits minimum, SHALL reset on every CLEAR/DRAW entry.
REQ-025 If the counter reaches WD_LIMIT without a qualified enable: control SHALL go to HOLD, the frame is abandoned, and timeout is set.
REQ-026 A tick arriving while not in HOLD SHALL be dropped, pulse overrun for that cycle, and leave direction latches unchanged.
REQ-027 A tick on the final DRAW exit cycle SHALL count as not-in-HOLD: it is dropped and overrun pulses.
REQ-028 Direction inputs SHALL be ignored except at the latch point in REQ-018.
REQ-029 Worst-case frame length SHALL be 2*(2*WD_LIMIT + 2*STEPS) + 1 cycles.

Reset
REQ-030 While reset_n is low: control = PREHOLD, PorB = 0, busy = 1, overrun = 0, timeout = 0, direction latches = 0, counters = 0.
REQ-031 After reset_n rises, the init sequence SHALL be PREHOLD for 1 cycle -> CLEAR with PorB=0 -> CLEAR with PorB=1 -> HOLD.
REQ-032 The init sequence has no moves and no DRAW; each CLEAR obeys REQ-022..025. This lets the datapath re-home both objects.
REQ-033 reset_n asserted mid-frame SHALL force REQ-030 values immediately, without waiting for a clock edge.

Verification
REQ-034 Scenario: reset release, enable model returns enable 4 cycles after each CLEAR entry -> PREHOLD, CLEAR/0 for 5 cycles, CLEAR/1 for 5 cycles, HOLD; busy falls with HOLD.
REQ-035 Scenario: STEPS=1, tick with p_right=1, p_up=1, bird idle -> CLEAR/0, RIGHT/0, UP/0, DRAW/0, CLEAR/1, DRAW/1, HOLD.
REQ-036 Scenario: STEPS=3, b_left=1 and b_right=1, b_down=1 -> bird sequence is CLEAR, DOWN x3, DRAW; no LEFT or RIGHT cycles.
REQ-037 Scenario: enable held constantly high -> each CLEAR/DRAW lasts exactly 2 cycles (REQ-023).
REQ-038 Scenario: enable never asserted, WD_LIMIT=255 -> HOLD after 255 cycles in CLEAR/0; timeout=1 and stays 1 through further ticks until reset.
REQ-039 Scenario: second tick during DRAW/1, and a tick asserted with reset_n low mid-move -> overrun pulses once with no extra frame; reset gives PREHOLD asynchronously.

Source files
------------

// File: rtl/movement_control.sv
// Frame sequencer for the crosshair/bird movement datapath.
// Each frame-strobe in HOLD latches the direction requests and then walks
// the datapath through CLEAR, the requested moves and DRAW, first for the
// crosshair and then for the bird. CLEAR/DRAW visits wait for the datapath's
// pass-complete flag, guarded by a watchdog that abandons the frame.
module movement_control #(
  parameter int WD_LIMIT = 255,
  parameter int STEPS    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       p_left,
  input  logic       p_right,
  input  logic       p_up,
  input  logic       p_down,
  input  logic       b_left,
  input  logic       b_right,
  input  logic       b_up,
  input  logic       b_down,
  input  logic       enable,
  output logic [3:0] control,
  output logic       PorB,
  output logic       busy,
  output logic       overrun,
  output logic       timeout
);

  // Counter must hold WD_LIMIT-1 and is never narrower than 8 bits.
  localparam int CW = ($clog2(WD_LIMIT + 1) > 8) ? $clog2(WD_LIMIT + 1) : 8;

  typedef enum logic [3:0] {
    PREHOLD = 4'b0100,
    HOLD    = 4'b0000,
    CLEAR   = 4'b0001,
    LEFT    = 4'b0011,
    RIGHT   = 4'b0010,
    DOWN    = 4'b0110,
    UP      = 4'b0111,
    DRAW    = 4'b0101
  } state_t;

  state_t          state;
  state_t          state_nxt;
  state_t          after_h;
  state_t          after_clear;
  logic            porb;
  logic            porb_nxt;
  logic            init_seq;
  logic            init_nxt;
  logic            restart;
  logic            wd_abort;
  logic            latch;
  logic [CW-1:0]   cnt;
  logic [3:0]      p_dir;
  logic [3:0]      b_dir;
  logic [3:0]      sel_dir;
  logic            go_left;
  logic            go_right;
  logic            go_up;
  logic            go_down;
  logic            visit_done;
  logic            wd_hit;
  logic            step_done;
  logic            timeout_q;

  // Direction bits are packed as {left, right, up, down}; opposing requests cancel.
  assign sel_dir  = porb ? b_dir : p_dir;
  assign go_left  = sel_dir[3] & ~sel_dir[2];
  assign go_right = sel_dir[2] & ~sel_dir[3];
  assign go_up    = sel_dir[1] & ~sel_dir[0];
  assign go_down  = sel_dir[0] & ~sel_dir[1];

  // The first cycle of a CLEAR/DRAW visit carries a stale enable from the previous pass.
  assign visit_done = (cnt != '0) && enable;
  assign wd_hit     = (cnt == CW'(WD_LIMIT - 1)) && !visit_done;
  assign step_done  = (cnt == CW'(STEPS - 1));

  // Next-state, object select and visit-restart decisions.
  always_comb begin
    state_nxt   = state;
    porb_nxt    = porb;
    init_nxt    = init_seq;
    restart     = 1'b0;
    wd_abort    = 1'b0;
    latch       = 1'b0;
    after_h     = DRAW;
    after_clear = DRAW;
    if (go_up) begin
      after_h = UP;
    end else if (go_down) begin
      after_h = DOWN;
    end
    if (go_left) begin
      after_clear = LEFT;
    end else if (go_right) begin
      after_clear = RIGHT;
    end else begin
      after_clear = after_h;
    end
    case (state)
      PREHOLD: begin
        state_nxt = CLEAR;
        porb_nxt  = 1'b0;
        restart   = 1'b1;
      end
      HOLD: begin
        if (tick) begin
          latch     = 1'b1;
          state_nxt = CLEAR;
          porb_nxt  = 1'b0;
          restart   = 1'b1;
        end
      end
      CLEAR: begin
        if (visit_done) begin
          restart = 1'b1;
          if (init_seq) begin
            if (!porb) begin
              state_nxt = CLEAR;
              porb_nxt  = 1'b1;
            end else begin
              state_nxt = HOLD;
              init_nxt  = 1'b0;
            end
          end else begin
            state_nxt = after_clear;
          end
        end else if (wd_hit) begin
          state_nxt = HOLD;
          wd_abort  = 1'b1;
          init_nxt  = 1'b0;
          restart   = 1'b1;
        end
      end
      LEFT, RIGHT: begin
        if (step_done) begin
          state_nxt = after_h;
          restart   = 1'b1;
        end
      end
      UP, DOWN: begin
        if (step_done) begin
          state_nxt = DRAW;
          restart   = 1'b1;
        end
      end
      DRAW: begin
        if (visit_done) begin
          restart = 1'b1;
          if (!porb) begin
            state_nxt = CLEAR;
            porb_nxt  = 1'b1;
          end else begin
            state_nxt = HOLD;
          end
        end else if (wd_hit) begin
          state_nxt = HOLD;
          wd_abort  = 1'b1;
          restart   = 1'b1;
        end
      end
      default: begin
        state_nxt = HOLD;
        restart   = 1'b1;
      end
    endcase
  end

  // State register, object select, init flag and per-visit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= PREHOLD;
      porb     <= 1'b0;
      init_seq <= 1'b1;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      porb     <= porb_nxt;
      init_seq <= init_nxt;
      if (restart || state == HOLD) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Direction latches load only on a frame-starting tick in HOLD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_dir <= 4'b0000;
      b_dir <= 4'b0000;
    end else if (latch) begin
      p_dir <= {p_left, p_right, p_up, p_down};
      b_dir <= {b_left, b_right, b_up, b_down};
    end
  end

  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
    end else if (wd_abort) begin
      timeout_q <= 1'b1;
    end
  end

  assign control = state;
  assign PorB    = porb;
  assign busy    = (state != HOLD);
  assign overrun = reset_n & tick & (state != HOLD);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_movement_control.sv
// Bench for movement_control: a behavioural model expands each frame into
// the expected per-cycle control/PorB trace and the enable pattern the
// datapath would produce, then the DUT is compared cycle by cycle.
module tb_movement_control;

  localparam int WD = 255;
  localparam int ST = 3;

  localparam logic [3:0] C_PRE   = 4'b0100;
  localparam logic [3:0] C_HOLD  = 4'b0000;
  localparam logic [3:0] C_CLR   = 4'b0001;
  localparam logic [3:0] C_LEFT  = 4'b0011;
  localparam logic [3:0] C_RIGHT = 4'b0010;
  localparam logic [3:0] C_DOWN  = 4'b0110;
  localparam logic [3:0] C_UP    = 4'b0111;
  localparam logic [3:0] C_DRAW  = 4'b0101;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       p_left = 1'b0, p_right = 1'b0, p_up = 1'b0, p_down = 1'b0;
  logic       b_left = 1'b0, b_right = 1'b0, b_up = 1'b0, b_down = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] control;
  logic       PorB;
  logic       busy;
  logic       overrun;
  logic       timeout;

  always #5 clk = ~clk;

  movement_control #(.WD_LIMIT(WD), .STEPS(ST)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick),
    .p_left(p_left), .p_right(p_right), .p_up(p_up), .p_down(p_down),
    .b_left(b_left), .b_right(b_right), .b_up(b_up), .b_down(b_down),
    .enable(enable), .control(control), .PorB(PorB), .busy(busy),
    .overrun(overrun), .timeout(timeout)
  );

  typedef struct {
    logic [3:0] ctl;
    logic       porb;
    logic       en;
    logic       tk;
    logic       tmo;
    logic [3:0] p;
    logic [3:0] b;
  } cyc_t;

  cyc_t q[$];
  bit   m_porb = 1'b0;
  bit   m_tmo  = 1'b0;
  bit   inj    = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void push(input logic [3:0] ctl, input logic porb, input logic en,
                               input logic tk, input logic [3:0] p, input logic [3:0] b);
    cyc_t e;
    e.ctl = ctl; e.porb = porb; e.en = en; e.tk = tk;
    e.tmo = m_tmo; e.p = p; e.b = b;
    q.push_back(e);
  endfunction

  // Non-HOLD cycle with random stray tick (when enabled) and random direction noise.
  function automatic void push_r(input logic [3:0] ctl, input logic porb, input logic en);
    logic tk;
    tk = inj && ($urandom_range(7, 0) == 0);
    push(ctl, porb, en, tk, 4'($urandom), 4'($urandom));
  endfunction

  // A CLEAR/DRAW visit whose enable rises at cycle 'start' and stays high.
  function automatic bit visit(input logic [3:0] code, input logic porb, input int start);
    int qual;
    int len;
    bit ok;
    qual = (start < 1) ? 1 : start;
    ok   = (qual < WD);
    len  = ok ? qual + 1 : WD;
    for (int i = 0; i < len; i++) push_r(code, porb, i >= start);
    if (!ok) m_tmo = 1'b1;
    return ok;
  endfunction

  // One object's pass: CLEAR, horizontal steps, vertical steps, DRAW. d = {l,r,u,d}.
  function automatic bit obj(input logic porb, input logic [3:0] d, input int sc, input int sd);
    m_porb = porb;
    if (!visit(C_CLR, porb, sc)) return 1'b0;
    if (d[3] != d[2])
      for (int i = 0; i < ST; i++) push_r(d[3] ? C_LEFT : C_RIGHT, porb, 1'($urandom));
    if (d[1] != d[0])
      for (int i = 0; i < ST; i++) push_r(d[1] ? C_UP : C_DOWN, porb, 1'($urandom));
    return visit(C_DRAW, porb, sd);
  endfunction

  function automatic void frame(input logic [3:0] p, input logic [3:0] b, input int s0,
                                input int s1, input int s2, input int s3, input bit last_tk);
    push(C_HOLD, m_porb, 1'($urandom), 1'b1, p, b);
    if (obj(1'b0, p, s0, s1)) void'(obj(1'b1, b, s2, s3));
    if (last_tk && q[q.size()-1].ctl == C_DRAW) q[q.size()-1].tk = 1'b1;
    push(C_HOLD, m_porb, 1'b0, 1'b0, 4'($urandom), 4'($urandom));
  endfunction

  function automatic void init_model(input int s0, input int s1);
    m_porb = 1'b0;
    push(C_PRE, 1'b0, 1'b0, 1'b0, 4'($urandom), 4'($urandom));
    if (visit(C_CLR, 1'b0, s0)) begin
      m_porb = 1'b1;
      void'(visit(C_CLR, 1'b1, s1));
    end
    push(C_HOLD, m_porb, 1'b0, 1'b0, 4'($urandom), 4'($urandom));
  endfunction

  // Plays n queued cycles; entered and left at one time unit after a rising edge.
  task automatic run_n(input int n);
    cyc_t e;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      e = q.pop_front();
      tick   = e.tk;
      enable = e.en;
      {p_left, p_right, p_up, p_down} = e.p;
      {b_left, b_right, b_up, b_down} = e.b;
      #1;
      chk("control", control, e.ctl);
      chk("porb", {3'b000, PorB}, {3'b000, e.porb});
      chk("busy", {3'b000, busy}, {3'b000, e.ctl != C_HOLD});
      chk("overrun", {3'b000, overrun}, {3'b000, e.tk && (e.ctl != C_HOLD)});
      chk("timeout", {3'b000, timeout}, {3'b000, e.tmo});
      @(posedge clk);
      #1;
    end
    tick   = 1'b0;
    enable = 1'b0;
  endtask

  task automatic run_all();
    run_n(q.size());
  endtask

  // Asserts reset asynchronously, checks reset values, then replays the init sequence.
  task automatic do_reset(input int s0, input int s1);
    reset_n = 1'b0;
    tick    = 1'b1;
    enable  = 1'b1;
    #1;
    chk("rst_control", control, C_PRE);
    chk("rst_porb", {3'b000, PorB}, 4'd0);
    chk("rst_busy", {3'b000, busy}, 4'd1);
    chk("rst_overrun", {3'b000, overrun}, 4'd0);
    chk("rst_timeout", {3'b000, timeout}, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    tick  = 1'b0;
    m_tmo = 1'b0;
    q.delete();
    init_model(s0, s1);
    reset_n = 1'b1;
    run_all();
  endtask

  initial begin
    int idx;
    @(posedge clk);
    #1;
    do_reset(4, 4);

    inj = 1'b0;
    frame(4'b0110, 4'b0000, 4, 4, 4, 4, 1'b0);
    run_all();
    frame(4'b0000, 4'b1101, 2, 3, 2, 3, 1'b0);
    run_all();
    frame(4'($urandom), 4'($urandom), 0, 0, 0, 0, 1'b0);
    run_all();
    frame(4'b1111, 4'b1010, 0, 1, 5, 0, 1'b1);
    run_all();

    inj = 1'b1;
    for (int f = 0; f < 25; f++) begin
      frame(4'($urandom), 4'($urandom), $urandom_range(8, 0), $urandom_range(8, 0),
            $urandom_range(8, 0), $urandom_range(8, 0), 1'($urandom));
      run_all();
    end

    inj = 1'b0;
    frame(4'b1000, 4'b0001, 1, 1, 1, 1, 1'b0);
    idx = 0;
    foreach (q[i]) if (idx == 0 && q[i].ctl == C_LEFT) idx = i;
    run_n(idx + 1);
    #2;
    do_reset(1, 3);

    frame(4'b0101, 4'b0011, 1000, 1, 1, 1, 1'b0);
    run_all();
    inj = 1'b1;
    for (int f = 0; f < 3; f++) begin
      frame(4'($urandom), 4'($urandom), $urandom_range(6, 0), $urandom_range(6, 0),
            $urandom_range(6, 0), $urandom_range(6, 0), 1'b1);
      run_all();
    end

    inj = 1'b0;
    do_reset(2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
